rr_arbiter_8: RTL

//  Round-robin arbiter sharing one resource among 8 requesters. Registered one-hot grant

---
 rtl/arb_pkg.sv | 28 ++
 rtl/onehot_dec8.sv | 15 +
 rtl/rr_arbiter_8.sv | 116 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and round-robin search for the 8-way arbiter.
// The search helper is reused by every arbiter instance.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Returns {found, idx}. last_ptr itself is the lowest-priority slot.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   last_ptr
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] c;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = last_ptr + IDX_W'(k);
            if (req[c]) res = {1'b1, c};
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_dec8.sv
// 3-to-8 one-hot decoder with enable; all-zero when disabled.
module onehot_dec8
    import arb_pkg::*;
(
    input  logic               i_en,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [NUM_REQ-1:0] o_dec
);

    always_comb begin
        o_dec = '0;
        if (i_en) o_dec[i_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W:0]   w_pick;
    logic             w_new;
    logic             w_to;
    logic             w_valid;

    assign w_valid = (r_state == ARB_GRANT);

    // While granted, the holder is the base so it ends up last in the scan.
    assign w_base = w_valid ? r_idx : r_last;
    assign w_pick = rr_pick(req, w_base);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_new       = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (en && w_pick[IDX_W]) begin
                    w_state_nxt = ARB_GRANT;
                    w_idx_nxt   = w_pick[IDX_W-1:0];
                    w_new       = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!req[r_idx] || w_to) begin
                    w_last_nxt = r_idx;
                    if (en && w_pick[IDX_W]) begin
                        w_idx_nxt = w_pick[IDX_W-1:0];
                        w_new     = 1'b1;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_idx   <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    assign w_to = w_valid && req[r_idx]
               && (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to;
            if (w_new)
                r_hold <= '0;
            else if (w_valid)
                r_hold <= r_hold + HOLD_W'(1);
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_hold;

    assign w_unused_hold = (MAX_HOLD > 0) & w_new;
    assign w_to          = 1'b0;
    assign timeout       = 1'b0;
`endif

    onehot_dec8 u_dec (
        .i_en  (w_valid),
        .i_idx (r_idx),
        .o_dec (gnt)
    );

    assign gnt_idx   = r_idx;
    assign gnt_valid = w_valid;

endmodule
